// File: rtl/bridge_reg_arbiter_pkg.sv
// Shared constants and FSM state type for the register-block write arbiter.
// The register block imports the same status address and clear masks.
package bridge_reg_pkg;

  localparam int unsigned ADDR_W     = 21;
  localparam int unsigned BYTECNT_W  = 2;
  localparam int unsigned REG_AW     = ADDR_W - BYTECNT_W;
  localparam int unsigned MAX_WAIT   = 16;

  localparam logic [REG_AW-1:0] STATUS_ADDR = 19'h00009;
  localparam logic [7:0]        CLR_MASK0   = 8'h04;  // addr_valid
  localparam logic [7:0]        CLR_MASK1   = 8'h02;  // instr_valid

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  function automatic logic [7:0] clr_mask(input logic [1:0] pend,
                                          input logic [7:0] m0,
                                          input logic [7:0] m1);
    return (pend[0] ? m0 : 8'h00) | (pend[1] ? m1 : 8'h00);
  endfunction

endpackage

// File: rtl/bridge_reg_arbiter_if.sv
// Bus bundle between USB front-end / bridge (master) and the write arbiter (slave).
interface bridge_reg_arbiter_if #(
  parameter int unsigned AW = 19
);
  logic [AW-1:0] usb_addr_i;
  logic [7:0]    usb_data_i;
  logic          usb_write_i;
  logic [7:0]    status_i;
  logic [1:0]    clr_req_i;
  logic [1:0]    clr_ack_o;
  logic [AW-1:0] reg_address_o;
  logic [7:0]    write_data_o;
  logic          reg_write_o;
  logic          busy_o;
  logic          starve_o;

  modport master (
    output usb_addr_i, usb_data_i, usb_write_i, status_i, clr_req_i,
    input  clr_ack_o, reg_address_o, write_data_o, reg_write_o, busy_o, starve_o
  );

  modport slave (
    input  usb_addr_i, usb_data_i, usb_write_i, status_i, clr_req_i,
    output clr_ack_o, reg_address_o, write_data_o, reg_write_o, busy_o, starve_o
  );
endinterface

// File: rtl/bridge_clr_tracker.sv
// Pending clear-request bits with re-arm, wait-age counter and sticky starve flag.
module bridge_clr_tracker
  import bridge_reg_pkg::*;
#(
  parameter logic [7:0]  pCLR_MASK0 = CLR_MASK0,
  parameter logic [7:0]  pCLR_MASK1 = CLR_MASK1,
  parameter int unsigned pMAX_WAIT  = MAX_WAIT
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [1:0] clr_req_i,
  input  logic       svc_i,       // all pending bits serviced this cycle
  output logic [1:0] pend_o,
  output logic [7:0] cmask_o,
  output logic       pend_nz_d_o,
  output logic       starve_o
);

  localparam int unsigned AGE_W = $clog2(pMAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(pMAX_WAIT);

  logic [1:0]       pend_q, pend_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             starve_q, starve_d;

  // A pulse arriving with service survives the clear and is handled later.
  always_comb begin
    pend_d = (svc_i ? 2'b00 : pend_q) | clr_req_i;
    age_d  = age_q;
    if (pend_q == 2'b00 || svc_i)
      age_d = '0;
    else if (age_q != AGE_MAX)
      age_d = age_q + 1'b1;
    starve_d = starve_q | (age_d == AGE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      pend_q   <= 2'b00;
      age_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      age_q    <= age_d;
      starve_q <= starve_d;
    end
  end

  assign pend_o      = pend_q;
  assign cmask_o     = clr_mask(pend_q, pCLR_MASK0, pCLR_MASK1);
  assign pend_nz_d_o = |pend_d;
  assign starve_o    = starve_q;

endmodule

// File: rtl/bridge_reg_arbiter.sv
// Registered arbiter for the register-block write port: USB writes win outright,
// status-flag clears are merged and applied as read-modify-write of the status register.
module bridge_reg_arbiter
  import bridge_reg_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH   = ADDR_W,
  parameter int unsigned pBYTECNT_SIZE = BYTECNT_W,
  parameter logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] pSTATUS_ADDR = STATUS_ADDR,
  parameter logic [7:0]  pCLR_MASK0    = CLR_MASK0,
  parameter logic [7:0]  pCLR_MASK1    = CLR_MASK1,
  parameter int unsigned pMAX_WAIT     = MAX_WAIT
) (
  input  logic                 clk,
  input  logic                 reset_i,
  bridge_reg_arbiter_if.slave  bus
);

  localparam int unsigned RAW = pADDR_WIDTH - pBYTECNT_SIZE;

  arb_state_e     state_q, state_d;
  logic           wr_q, wr_d;
  logic [RAW-1:0] addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [1:0]     ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           svc;
  logic [1:0]     pend;
  logic [7:0]     cmask;
  logic           pend_nz_d;
  logic           starve;

  bridge_clr_tracker #(
    .pCLR_MASK0 (pCLR_MASK0),
    .pCLR_MASK1 (pCLR_MASK1),
    .pMAX_WAIT  (pMAX_WAIT)
  ) u_trk (
    .clk         (clk),
    .reset_i     (reset_i),
    .clr_req_i   (bus.clr_req_i),
    .svc_i       (svc),
    .pend_o      (pend),
    .cmask_o     (cmask),
    .pend_nz_d_o (pend_nz_d),
    .starve_o    (starve)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    addr_d  = '0;
    data_d  = 8'h00;
    ack_d   = 2'b00;
    svc     = 1'b0;
    if (bus.usb_write_i) begin
      wr_d   = 1'b1;
      addr_d = bus.usb_addr_i;
      data_d = bus.usb_data_i;
      if (state_q == WAIT) begin
        state_d = IDLE;
      end else if (pend != 2'b00 && bus.usb_addr_i == pSTATUS_ADDR) begin
        // USB write to status absorbs the pending clears in the same write.
        data_d  = bus.usb_data_i & ~cmask;
        ack_d   = pend;
        svc     = 1'b1;
        state_d = WAIT;
      end
    end else if (state_q == WAIT) begin
      state_d = IDLE;
    end else if (pend != 2'b00) begin
      svc   = 1'b1;
      ack_d = pend;
      // Bits already clear need no write, just the ack.
      if ((bus.status_i & cmask) != 8'h00) begin
        wr_d    = 1'b1;
        addr_d  = pSTATUS_ADDR;
        data_d  = bus.status_i & ~cmask;
        state_d = WAIT;
      end
    end
    busy_d = pend_nz_d | (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.reg_write_o   = wr_q;
  assign bus.reg_address_o = addr_q;
  assign bus.write_data_o  = data_q;
  assign bus.clr_ack_o     = ack_q;
  assign bus.busy_o        = busy_q;
  assign bus.starve_o      = starve;

endmodule

// File: doc/bridge_reg_arbiter.md
Name: bridge_reg_arbiter

Overview:
- Registered arbiter for the single write port of the register block. It is shared by USB front-end writes and the bridge's status-flag clear requests: addr_valid clear (bit 2) and instr_valid clear (bit 1).
- Replaces the combinational priority mux in the top level.
- Guarantees that USB writes are never dropped or delayed by more than one cycle. Clear requests are queued, merged, and applied as read-modify-write of the status register.
- Sits in the clk domain of the register block, between the USB front-end, the bridge and the register block.

Parameters:
- pADDR_WIDTH, 21, USB address width.
- pBYTECNT_SIZE, 2, byte-count bits; register address width is pADDR_WIDTH-pBYTECNT_SIZE.
- pSTATUS_ADDR, 19'h00009, register address of the bridge status register.
- pCLR_MASK0, 8'h04, status bits cleared by request 0 (addr_valid).
- pCLR_MASK1, 8'h02, status bits cleared by request 1 (instr_valid).
- pMAX_WAIT, 16, cycles a pending clear may wait before starve_o is set.

Ports:
- clk  in  1  clock (same clock as register block writes)
- reset_i  in  1  synchronous, active-high reset
- usb_addr_i  in  pADDR_WIDTH-pBYTECNT_SIZE  USB front-end register address
- usb_data_i  in  8  USB front-end write data
- usb_write_i  in  1  USB write strobe, one cycle per byte
- status_i  in  8  current value of status register (read-back)
- clr_req_i  in  2  clear-request pulses; bit0 = addr_valid, bit1 = instr_valid
- clr_ack_o  out  2  one-cycle ack per serviced request
- reg_address_o  out  pADDR_WIDTH-pBYTECNT_SIZE  write address to register block
- write_data_o  out  8  write data to register block
- reg_write_o  out  1  write strobe to register block
- busy_o  out  1  pending clears exist or FSM is in WAIT
- starve_o  out  1  sticky: a clear waited at least pMAX_WAIT cycles

Behaviour:
- All outputs are registered. Reset value of every output and internal register is 0; state = IDLE; pend = 2'b00; age = 0.
- Reset mid-operation discards pending requests with no ack.
- pend[i] is set by a clr_req_i[i] pulse and cleared when serviced. A repeated pulse while pending merges and yields one ack. A pulse in the same cycle that bit i is serviced leaves pend[i] set (re-armed, serviced later).
- cmask = (pend[0] ? pCLR_MASK0 : 0) | (pend[1] ? pCLR_MASK1 : 0).
- USB priority is absolute. If usb_write_i = 1, the next cycle reg_write_o = 1, reg_address_o = usb_addr_i, write_data_o = usb_data_i. This holds in both IDLE and WAIT (latency 1).
- Merge case: USB write to pSTATUS_ADDR while pend != 0 → write_data_o = usb_data_i & ~cmask; all pend bits are acked in the same cycle as reg_write_o; pend cleared; go to WAIT.
- FSM states: IDLE, WAIT.
- IDLE, no usb_write_i, pend != 0, (status_i & cmask) == 0 → ack all pend the next cycle with no write; stay IDLE.
- IDLE, no usb_write_i, pend != 0, otherwise → next cycle reg_write_o = 1, reg_address_o = pSTATUS_ADDR, write_data_o = status_i & ~cmask, ack pend; go to WAIT.
- WAIT lasts exactly 1 cycle so that status_i reflects the write before the next read-modify-write. No clear is issued in WAIT. USB writes are forwarded without merging. Return to IDLE.
- Writes from a clear are a single merged write even when both bits are pending.
- age counter: increments each cycle pend != 0 and no service occurs; resets to 0 on service or when pend == 0; saturates at pMAX_WAIT. When it reaches pMAX_WAIT, starve_o = 1 until reset. No forced preemption of USB.
- busy_o = (pend != 0) | (state == WAIT), registered.

Decomposition:
- Package bridge_reg_pkg holds the FSM state enum (IDLE, WAIT), the status register address, and the clear-mask constants, so the top level and the register block share them.
- One natural sub-module: bridge_clr_tracker, covering pend bits, re-arm logic, the age counter and starve_o. The FSM and output register stay in the parent.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, busy_o = 0.
- usb_write_i with addr 19'h00003, data 8'hA5 → 1 cycle later reg_write_o = 1, addr 19'h00003, data 8'hA5; no ack.
- status_i = 8'h06, clr_req_i = 2'b11 in one cycle, no USB traffic:
  - next cycle one write of 8'h00 to pSTATUS_ADDR with clr_ack_o = 2'b11;
  - following cycle WAIT with reg_write_o = 0.
- status_i = 8'h02, clr_req_i = 2'b01 → clr_ack_o = 2'b01 with no reg_write_o (bit already clear).
- pend = 2'b10, then usb_write_i to pSTATUS_ADDR with data 8'hFF → write_data_o = 8'hFD, clr_ack_o = 2'b10 in the same cycle.
- clr_req_i = 2'b01 plus usb_write_i every cycle for 20 cycles to a non-status address:
  - every USB write is forwarded;
  - starve_o rises at cycle 16 and stays high;
  - once USB stops, the clear is serviced.
- Reset asserted while pend = 2'b01 → no ack ever issued; pend = 0.
